// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the program loader, instruction fetch
// and load/store unit. One transaction is in flight at a time: IDLE -> ISSUE -> (WAIT) -> ACK.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_req,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_wdata,
  output logic                ld_ack,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_ack,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          grant_id
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_LD   = 2'd1,
    GNT_IF   = 2'd2,
    GNT_LS   = 2'd3
  } gnt_t;

  state_t           state;
  gnt_t             grant_q;
  gnt_t             last_rr;
  gnt_t             win;
  logic [CNT_W-1:0] cnt;
  logic             mem_en_q;
  logic             ld_ack_q;
  logic             if_ack_q;
  logic             ls_ack_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    win = GNT_NONE;
    if (ld_req)                win = GNT_LD;
    else if (if_req && ls_req) win = (last_rr == GNT_IF) ? GNT_LS : GNT_IF;
    else if (if_req)           win = GNT_IF;
    else if (ls_req)           win = GNT_LS;
  end

  // The mem_* registers double as the latched request: loaded at grant, driven in
  // ISSUE, cleared afterwards so the memory sees zeros outside the issue cycle.
  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_q   <= GNT_NONE;
      last_rr   <= GNT_LS;
      cnt       <= '0;
      mem_en_q  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      ld_ack_q  <= 1'b0;
      if_ack_q  <= 1'b0;
      ls_ack_q  <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win != GNT_NONE) begin
            grant_q  <= win;
            mem_en_q <= 1'b1;
            state    <= ISSUE;
            case (win)
              GNT_LD: begin
                mem_we    <= 1'b1;
                mem_addr  <= ld_addr;
                mem_wdata <= ld_wdata;
                mem_wstrb <= {STRB_W{1'b1}};
              end
              GNT_IF: begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_wstrb <= '0;
                last_rr   <= GNT_IF;
              end
              default: begin
                mem_we    <= ls_we;
                mem_addr  <= ls_addr;
                mem_wdata <= ls_wdata;
                mem_wstrb <= ls_wstrb;
                last_rr   <= GNT_LS;
              end
            endcase
          end
        end
        ISSUE: begin
          mem_en_q  <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_wstrb <= '0;
          cnt       <= '0;
          if (mem_we) begin
            ld_ack_q <= (grant_q == GNT_LD);
            ls_ack_q <= (grant_q == GNT_LS);
            state    <= ACK;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            if (grant_q == GNT_IF) begin
              if_rdata <= mem_rdata;
              if_ack_q <= 1'b1;
            end else begin
              ls_rdata <= mem_rdata;
              ls_ack_q <= 1'b1;
            end
            state <= ACK;
          end
        end
        default: begin
          ld_ack_q <= 1'b0;
          if_ack_q <= 1'b0;
          ls_ack_q <= 1'b0;
          grant_q  <= GNT_NONE;
          state    <= IDLE;
        end
      endcase
    end
  end

  // A reset landing mid-transaction must not let an issue or ack escape in that cycle.
  assign mem_en   = mem_en_q & ~rst;
  assign ld_ack   = ld_ack_q & ~rst;
  assign if_ack   = if_ack_q & ~rst;
  assign ls_ack   = ls_ack_q & ~rst;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LATENCY=1, one at 3, sharing
// requester inputs; memory read data is a per-cycle pattern so capture timing is visible.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        ld_req, if_req, ls_req, ls_we;
  logic [31:0] ld_addr, ld_wdata, if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [3:0]  ls_wstrb;

  logic        ld_ack, if_ack, ls_ack, mem_en, mem_we;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  grant_id;

  logic        ld_ack3, if_ack3, ls_ack3, mem_en3, mem_we3;
  logic [31:0] if_rdata3, ls_rdata3, mem_addr3, mem_wdata3;
  logic [3:0]  mem_wstrb3;
  logic [1:0]  grant_id3;

  logic [31:0] cyc;
  logic [31:0] hit_cyc, hit_val;
  int          checks, errors;
  logic [7:0]  glog[$];
  int          n_if, n_ls, n_ld, n3, b2b;
  logic        prev_en;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .grant_id(grant_id)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack3),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack3), .if_rdata(if_rdata3),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_ack(ls_ack3), .ls_rdata(ls_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_wstrb(mem_wstrb3), .mem_rdata(mem_rdata), .grant_id(grant_id3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  // Read data differs every cycle, so only a capture in exactly the right cycle matches.
  assign mem_rdata = (cyc == hit_cyc) ? hit_val : (32'hA500_0000 | cyc);

  initial begin
    n_if = 0; n_ls = 0; n_ld = 0; n3 = 0; b2b = 0; prev_en = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_en) glog.push_back({grant_id, mem_we, 1'b0, mem_wstrb});
      if (mem_en && prev_en) b2b++;
      prev_en = mem_en;
      if (if_ack) n_if++;
      if (ls_ack) n_ls++;
      if (ld_ack) n_ld++;
      if (ld_ack3 || if_ack3 || ls_ack3) n3++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic any1, any3;
  assign any1 = |{ld_ack, if_ack, if_rdata, ls_ack, ls_rdata, mem_en, mem_we,
                  mem_addr, mem_wdata, mem_wstrb, grant_id};
  assign any3 = |{ld_ack3, if_ack3, if_rdata3, ls_ack3, ls_rdata3, mem_en3, mem_we3,
                  mem_addr3, mem_wdata3, mem_wstrb3, grant_id3};

  initial begin
    int t, g0, i0, s0, b0, l0, a0, nld;
    logic [7:0] exp_ct[4];
    logic [7:0] exp_ld[5];
    exp_ct = '{8'h80, 8'hC0, 8'h80, 8'hC0};
    exp_ld = '{8'h6F, 8'h6F, 8'h6F, 8'h80, 8'hC0};
    checks = 0; errors = 0;
    rst = 1'b1;
    ld_req = 0; if_req = 0; ls_req = 0; ls_we = 0;
    ld_addr = '0; ld_wdata = '0; if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
    hit_cyc = '1; hit_val = '0;
    step(); step();
    check("rst_outs_l1", any1, 0);
    check("rst_outs_l3", any3, 0);
    rst = 1'b0;

    // Single IFU read, latency 1
    t = int'(cyc);
    if_req = 1; if_addr = 32'h8000_0000;
    hit_cyc = 32'(t + 2); hit_val = 32'h0000_0013;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("if_en_c%0d", k), mem_en, (k == 1));
      check($sformatf("if_ack_c%0d", k), if_ack, (k == 3));
      check($sformatf("if_gnt_c%0d", k), grant_id, (k <= 3) ? 2 : 0);
      if (k == 1) begin
        check("if_addr", mem_addr, 32'h8000_0000);
        check("if_we", mem_we, 0);
      end
      if (if_ack) if_req = 0;
    end
    check("if_rdata", if_rdata, 32'h13);
    step(); step(); step();
    check("if_rdata_held", if_rdata, 32'h13);

    // LSU byte store
    ls_req = 1; ls_we = 1; ls_addr = 32'h100; ls_wdata = 32'hAB; ls_wstrb = 4'h1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("st_en_c%0d", k), mem_en, (k == 1));
      check($sformatf("st_ack_c%0d", k), ls_ack, (k == 2));
      if (k == 1) begin
        check("st_we", mem_we, 1);
        check("st_wstrb", mem_wstrb, 4'h1);
        check("st_addr", mem_addr, 32'h100);
        check("st_wdata", mem_wdata, 32'hAB);
      end
      if (ls_ack) ls_req = 0;
    end
    check("st_idle_mem", {mem_we, mem_wstrb, mem_addr, mem_wdata}, 0);

    // IFU/LSU contention after reset
    pulse_rst();
    ls_we = 0; ls_wstrb = 0; ls_addr = 32'h200; if_addr = 32'h8000_0004;
    g0 = glog.size(); i0 = n_if; s0 = n_ls; b0 = b2b;
    if_req = 1; ls_req = 1;
    repeat (15) step();
    if_req = 0; ls_req = 0;
    repeat (4) step();
    check("ct_ngrants", glog.size() - g0, 4);
    for (int i = 0; i < 4; i++)
      if (g0 + i < glog.size()) check($sformatf("ct_grant%0d", i), glog[g0 + i], exp_ct[i]);
    check("ct_if_acks", n_if - i0, 2);
    check("ct_ls_acks", n_ls - s0, 2);
    check("ct_b2b_en", b2b - b0, 0);

    // Loader priority, dropped after its third ack
    pulse_rst();
    g0 = glog.size(); l0 = n_ld; nld = 0;
    ld_req = 1; ld_addr = 32'h0; ld_wdata = 32'h1111;
    if_req = 1; ls_req = 1;
    for (int k = 0; k < 30 && nld < 3; k++) begin
      step();
      if (ld_ack) begin
        nld++;
        ld_addr = ld_addr + 4;
      end
    end
    check("ld_three_acks", nld, 3);
    ld_req = 0;
    repeat (8) step();
    if_req = 0; ls_req = 0;
    repeat (4) step();
    check("ld_ngrants", glog.size() - g0, 5);
    for (int i = 0; i < 5; i++)
      if (g0 + i < glog.size()) check($sformatf("ld_grant%0d", i), glog[g0 + i], exp_ld[i]);
    check("ld_acks", n_ld - l0, 3);

    // Latency-3 LSU read on the second instance
    pulse_rst();
    t = int'(cyc);
    ls_req = 1; ls_we = 0; ls_addr = 32'h300;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("l3_en_c%0d", k), mem_en3, (k == 1));
      check($sformatf("l3_ack_c%0d", k), ls_ack3, (k == 5));
      if (ls_ack3) ls_req = 0;
    end
    check("l3_rdata", ls_rdata3, 32'hA500_0000 | 32'(t + 4));
    step(); step();
    check("l3_rdata_held", ls_rdata3, 32'hA500_0000 | 32'(t + 4));

    // Reset during WAIT aborts the read; IFU wins the next tie
    pulse_rst();
    repeat (2) step();
    if_req = 1; if_addr = 32'h40;
    step();
    check("ab_issue", mem_en, 1);
    step();
    rst = 1; if_req = 0;
    step();
    check("ab_outs_l1", any1, 0);
    check("ab_outs_l3", any3, 0);
    rst = 0;
    i0 = n_if; a0 = n3;
    repeat (4) step();
    check("ab_no_ack_l1", n_if - i0, 0);
    check("ab_no_ack_l3", n3 - a0, 0);
    if_req = 1; ls_req = 1;
    step();
    check("ab_first_gnt_l1", grant_id, 2);
    check("ab_first_gnt_l3", grant_id3, 2);
    if_req = 0; ls_req = 0;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
